// File: rtl/alu_ctrl_pkg.sv
// Shared constants for alu_ctrl: ALU function codes, RV32I opcode/funct fields, FSM states.
package alu_ctrl_pkg;

    // ALU function codes
    localparam int unsigned ALU_FUNCT_WIDTH = 3;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_ADD = 3'd0;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_SUB = 3'd1;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_XOR = 3'd2;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_OR  = 3'd3;
    localparam logic [ALU_FUNCT_WIDTH-1:0] ALU_FUNCT_AND = 3'd4;

    // RV32I opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // funct3 / funct7 fields
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef struct packed {
        logic [ALU_FUNCT_WIDTH-1:0] funct;
        logic                       illegal;
        logic                       use_imm;
    } dec_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU: add/sub/xor/or/and with zero, equal and signed-overflow flags.
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]               x,
    input  logic [N-1:0]               y,
    input  logic [ALU_FUNCT_WIDTH-1:0] funct,
    output logic [N-1:0]               z,
    output logic                       zero,
    output logic                       equal,
    output logic                       overflow
);

    logic [N-1:0] sum;
    logic [N-1:0] diff;

    assign sum  = x + y;
    assign diff = x - y;

    // Select result and flag signed overflow for add/sub
    always_comb begin
        z        = '0;
        overflow = 1'b0;
        case (funct)
            ALU_FUNCT_ADD: begin
                z        = sum;
                overflow = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
            end
            ALU_FUNCT_SUB: begin
                z        = diff;
                overflow = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
            end
            ALU_FUNCT_XOR: z = x ^ y;
            ALU_FUNCT_OR:  z = x | y;
            ALU_FUNCT_AND: z = x & y;
            default:       z = '0;
        endcase
    end

    assign zero  = (z == '0);
    assign equal = (x == y);

endmodule

// File: rtl/alu_ctrl.sv
// Decode-and-issue controller for the integer ALU (IDLE -> EXEC -> DONE).
// Optional feature: define ALU_CTRL_IMM_EN to also decode OP-IMM (ADDI/XORI/ORI/ANDI).
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  instr,
    input  logic [N-1:0] rs1_val,
    input  logic [N-1:0] rs2_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [4:0]   rd,
    output logic         zero,
    output logic         illegal
);

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.funct   = ALU_FUNCT_ADD;
        d.illegal = 1'b1;
        d.use_imm = 1'b0;
        case (ins[6:0])
            OPC_OP: begin
                if (ins[31:25] == F7_BASE) begin
                    d.illegal = 1'b0;
                    case (ins[14:12])
                        F3_ADD_SUB: d.funct = ALU_FUNCT_ADD;
                        F3_XOR:     d.funct = ALU_FUNCT_XOR;
                        F3_OR:      d.funct = ALU_FUNCT_OR;
                        F3_AND:     d.funct = ALU_FUNCT_AND;
                        default:    d.illegal = 1'b1;
                    endcase
                end else if (ins[31:25] == F7_SUB && ins[14:12] == F3_ADD_SUB) begin
                    d.illegal = 1'b0;
                    d.funct   = ALU_FUNCT_SUB;
                end
            end
`ifdef ALU_CTRL_IMM_EN
            OPC_OP_IMM: begin
                d.illegal = 1'b0;
                d.use_imm = 1'b1;
                case (ins[14:12])
                    F3_ADD_SUB: d.funct = ALU_FUNCT_ADD;
                    F3_XOR:     d.funct = ALU_FUNCT_XOR;
                    F3_OR:      d.funct = ALU_FUNCT_OR;
                    F3_AND:     d.funct = ALU_FUNCT_AND;
                    default:    d.illegal = 1'b1;
                endcase
            end
`endif
            default: ;
        endcase
        return d;
    endfunction

    state_e                     state_q, state_d;
    logic [N-1:0]               x_q, x_d, y_q, y_d;
    logic [ALU_FUNCT_WIDTH-1:0] funct_q, funct_d;
    logic [4:0]                 rd_q, rd_d;
    logic                       illegal_q, illegal_d;
    logic [N-1:0]               result_q, result_d;
    logic                       zero_q, zero_d;
    logic                       out_valid_q, out_valid_d;

    logic         ready_int;
    logic         accept;
    dec_t         dec;
    logic [N-1:0] y_sel;
    logic [N-1:0] alu_z;
    logic         alu_zero;
    logic         alu_equal_unused;
    logic         alu_overflow_unused;
    logic         unused_instr;

    // rst_n only gates the port, keeping reset out of the flop data paths
    assign ready_int = (state_q == StIdle) || (state_q == StDone && out_ready);
    assign in_ready  = rst_n && ready_int;
    assign accept    = in_valid && ready_int;
    assign dec       = decode(instr);
    assign unused_instr = ^instr[24:15];

`ifdef ALU_CTRL_IMM_EN
    assign y_sel = dec.use_imm ? {{(N-12){instr[31]}}, instr[31:20]} : rs2_val;
`else
    assign y_sel = rs2_val;
`endif

    alu #(
        .N(N)
    ) u_alu (
        .x        (x_q),
        .y        (y_q),
        .funct    (funct_q),
        .z        (alu_z),
        .zero     (alu_zero),
        .equal    (alu_equal_unused),
        .overflow (alu_overflow_unused)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        funct_d     = funct_q;
        rd_d        = rd_q;
        illegal_d   = illegal_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            x_d       = rs1_val;
            y_d       = y_sel;
            funct_d   = dec.funct;
            rd_d      = instr[11:7];
            illegal_d = dec.illegal;
        end
        case (state_q)
            StIdle: begin
                if (accept) state_d = StExec;
            end
            StExec: begin
                // Illegal ops still complete, with a forced zero result
                result_d    = illegal_q ? '0 : alu_z;
                zero_d      = illegal_q | alu_zero;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = accept ? StExec : StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = StIdle;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            x_q         <= '0;
            y_q         <= '0;
            funct_q     <= ALU_FUNCT_ADD;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            funct_q     <= funct_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign rd        = rd_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed steps plus randomized instructions vs a reference model.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        zero;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    alu_ctrl #(
        .N(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd        (rd),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model from the ISA rules: returns {illegal, zero, result}
    function automatic logic [33:0] model(input logic [31:0] ins, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] r;
        logic        ill;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        imm = {{20{ins[31]}}, ins[31:20]};
        r   = 32'd0;
        ill = 1'b0;
        if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0)      r = a + b;
        else if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) r = a - b;
        else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd4) r = a ^ b;
        else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd6) r = a | b;
        else if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd7) r = a & b;
`ifdef ALU_CTRL_IMM_EN
        else if (opc == 7'h13 && f3 == 3'd0) r = a + imm;
        else if (opc == 7'h13 && f3 == 3'd4) r = a ^ imm;
        else if (opc == 7'h13 && f3 == 3'd6) r = a | imm;
        else if (opc == 7'h13 && f3 == 3'd7) r = a & imm;
`endif
        else ill = 1'b1;
        return {ill, (r == 32'd0), r};
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rdf, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rdf, opc};
    endfunction

    // Issue one instruction with out_ready high and check 2-cycle latency and bundle
    task automatic do_op(input string tag, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                         input logic exp_ill);
        int n;
        @(negedge clk);
        instr = ins; rs1_val = a; rs2_val = b; in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
        chk({tag, "_lat_exec"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, result, exp_r);
        chk({tag, "_rd"}, {27'd0, rd}, {27'd0, ins[11:7]});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
        chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    endtask

    initial begin
        logic [33:0] m;
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sv_r;
        logic        ok;
        logic [6:0]  f7s [3];
        logic [2:0]  f3s;
        f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_val = '0; rs2_val = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed cases
        do_op("add", mk(7'h00, 3'd0, 5'd3, 7'h33), 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        do_op("sub_neg", mk(7'h20, 3'd0, 5'd4, 7'h33), 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("sub_zero", mk(7'h20, 3'd0, 5'd5, 7'h33), 32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
        do_op("sll_ill", mk(7'h00, 3'd1, 5'd6, 7'h33), 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
        ins = {12'hFFF, 5'd1, 3'd0, 5'd7, 7'h13};
`ifdef ALU_CTRL_IMM_EN
        do_op("addi", ins, 32'd10, 32'h5555, 32'd9, 1'b0, 1'b0);
`else
        do_op("addi_ill", ins, 32'd10, 32'h5555, 32'd0, 1'b1, 1'b1);
`endif

        // Backpressure: hold DONE for 5 cycles
        @(negedge clk);
        instr = mk(7'h00, 3'd6, 5'd9, 7'h33); rs1_val = 32'hF0; rs2_val = 32'h0F;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
        @(negedge clk);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && result === 32'hFF && rd === 5'd9
                  && zero === 1'b0 && illegal === 1'b0)) ok = 1'b0;
        end
        chk("bp_stable", {31'd0, ok}, 32'd1);
        // Release with a new instruction in the same cycle
        instr = mk(7'h00, 3'd7, 5'd10, 7'h33); rs1_val = 32'hFF00; rs2_val = 32'h0FF0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("bb_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bb_exec", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("bb_valid", {31'd0, out_valid}, 32'd1);
        chk("bb_result", result, 32'h0F00);
        chk("bb_rd", {27'd0, rd}, 32'd10);

        // Randomized instructions against the model
        for (int i = 0; i < 40; i++) begin
            f3s = 3'($urandom_range(0, 7));
            ins = mk(f7s[$urandom_range(0, 2)], f3s, 5'($urandom), 7'h33);
            if ($urandom_range(0, 5) == 0) ins[6:0] = 7'h13;
            if ($urandom_range(0, 9) == 0) ins[31:20] = 12'($urandom);
            if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? a : $urandom;
            m = model(ins, a, b);
            do_op("rand", ins, a, b, m[31:0], m[32], m[33]);
        end

        // Reset pulse during EXEC discards the instruction
        @(negedge clk);
        instr = mk(7'h00, 3'd0, 5'd11, 7'h33); rs1_val = 32'd3; rs2_val = 32'd4;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_rd", {27'd0, rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        chk("post_rst_no_out", {31'd0, ok}, 32'd1);

        // Still functional afterwards
        sv_r = 32'hDEAD_0000 ^ 32'h0000_BEEF;
        do_op("post_xor", mk(7'h00, 3'd4, 5'd12, 7'h33), 32'hDEAD_0000, 32'h0000_BEEF, sv_r,
              1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Decode-and-issue controller for the processor's ALU: accepts one RV32I integer ALU instruction with its register operands over a valid/ready handshake. It decodes opcode/funct3/funct7 into an ALU function code, drives an internal `alu` instance with registered operands, and returns the captured result and flags to writeback over a second valid/ready handshake. It sits between the register-read stage and writeback.

## Interface
- `N`, default 32: datapath width.
- `clk`, input, 1: single clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: instruction and operands valid.
- `in_ready`, output, 1: block can accept an instruction this cycle.
- `instr`, input, 32: raw instruction word.
- `rs1_val`, input, N: source register 1 value.
- `rs2_val`, input, N: source register 2 value.
- `out_valid`, output, 1: result bundle valid.
- `out_ready`, input, 1: writeback accepts the bundle.
- `result`, output, N: ALU result, or 0 if illegal.
- `rd`, output, 5: destination register, `instr[11:7]`.
- `zero`, output, 1: `result == 0`, from the ALU zero flag.
- `illegal`, output, 1: instruction not supported by this block.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, register the operands, `rd` and the decoded funct/illegal bit, then go to EXEC.
- EXEC: the ALU computes combinationally from the registered operands. Capture `z` into `result` and the zero flag into `zero`, then go to DONE.
- DONE: `out_valid`=1. The bundle stays stable until `out_ready`. On `out_ready`, the next state is IDLE, unless a new instruction is accepted in the same cycle, in which case it is EXEC.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready).
- Decode is legal only for opcode 0110011 (OP):
  - funct3 000 with funct7 0000000: ADD.
  - funct3 000 with funct7 0100000: SUB.
  - funct3 100, 110, 111 with funct7 0000000: XOR, OR, AND.
- Function codes come from the `ALU_FUNCT_*` defines, width `ALU_FUNCT_WIDTH`.
- Anything else is illegal. Illegal instructions still complete: `illegal`=1, `result`=0, `zero`=1, same latency.
- Arithmetic is modulo 2^N with no overflow reporting. SUB computes rs1 − rs2.
- y operand: `rs2_val` for OP instructions.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`=1 after reset deasserts, 0 while `rst_n`=0.
  - `out_valid`=0.
  - `result`=0, `rd`=0, `zero`=0, `illegal`=0.
- Latency: handshake at edge T, state EXEC during T→T+1, `out_valid` high after edge T+1.
- Throughput: one instruction per 2 cycles with `out_ready` held high.
- Backpressure: with `out_ready` low, DONE holds indefinitely and `in_ready` stays 0. Outputs do not change.
- `instr`, `rs1_val` and `rs2_val` are don't-care after the handshake.
- Reset mid-operation from any state: the in-flight instruction is discarded, no output is produced, and outputs take their reset values immediately.

## Configuration
- `ALU_CTRL_IMM_EN` defined: also decodes opcode 0010011 (OP-IMM).
  - funct3 000 → ADD, 100 → XOR, 110 → OR, 111 → AND.
  - y = `instr[31:20]` sign-extended to N bits; `rs2_val` is ignored.
- `ALU_CTRL_IMM_EN` undefined: OP-IMM decodes as illegal.

## Structure
- Opcode constants (OP, OP-IMM), funct3/funct7 constants and FSM state encodings go in the shared header alongside the existing `ALU_FUNCT_*` definitions.
- One sub-module: an instance of `alu` with parameter `N`. The `equal` and `overflow` outputs are unused.
- Decode is a combinational function inside `alu_ctrl`.

## Test plan
- ADD (funct7 0, funct3 000): rs1=5, rs2=7, rd=3, `out_ready`=1 → `out_valid` 2 cycles after handshake; `result`=12, `rd`=3, `zero`=0, `illegal`=0.
- SUB: rs1=0, rs2=1 → `result`=0xFFFFFFFF. SUB with rs1=rs2=0x1234 → `result`=0, `zero`=1.
- Illegal SLL (funct3 001): rs1=1, rs2=1 → `illegal`=1, `result`=0, `zero`=1, same 2-cycle latency.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → bundle unchanged and `in_ready`=0 throughout. Raise `out_ready` with `in_valid`=1 → back-to-back acceptance, next result 2 cycles later.
- With `ALU_CTRL_IMM_EN`: ADDI imm=0xFFF, rs1=10 → `result`=9. Without it, the same instruction → `illegal`=1.
- Pulse `rst_n` low during EXEC → `out_valid` never asserts for that instruction; `in_ready`=1 on the first cycle after release.
